mem_arbiter: RTL
================

# mem_arbiter

Arbitrates N cache miss/write-back ports (I-cache, D-cache, …) onto a single shared slow-memory port, replacing the per-cache dedicated memory buses. Each channel presents the standard cache-side memory handshake (read/write/addr/wdata held until ready), and the arbiter serialises the transactions. Each request is registered at grant. The line is returned with a one-cycle ready pulse to the winning channel. It sits between the cache instances and the external memory interface of the top level.

## Interface
- N_CH, 2, number of requesting channels (≥2)
- ADDR_W, 28, line address width (byte address bits 31:4)
- LINE_W, 128, cache line width in bits
- clk  input  1  clock, all state updates on rising edge
- proc_reset  input  1  asynchronous, active-high reset
- ch_read  input  N_CH  per-channel line read request, held until ch_ready
- ch_write  input  N_CH  per-channel line write request, held until ch_ready
- ch_addr  input  N_CH*ADDR_W  packed line addresses; channel i at [i*ADDR_W +: ADDR_W]
- ch_wdata  input  N_CH*LINE_W  packed write lines; channel i at [i*LINE_W +: LINE_W]
- ch_rdata  output  LINE_W  registered read line, shared by all channels
- ch_ready  output  N_CH  one-hot, one-cycle completion pulse
- mem_read  output  1  memory read strobe, registered
- mem_write  output  1  memory write strobe, registered
- mem_addr  output  ADDR_W  registered line address
- mem_wdata  output  LINE_W  registered write line
- mem_rdata  input  LINE_W  memory read data, valid with mem_ready
- mem_ready  input  1  memory completion, one-cycle pulse

## Operation
- Channel i requests when ch_read[i] | ch_write[i].
- If both are set, the write wins: mem_write=1 and mem_read=0.
- FSM states are IDLE, BUSY and RESP.
- IDLE: if any channel requests, select the winner, store it in grant, capture its addr/wdata/op into the mem_* registers, then go to BUSY. Otherwise stay in IDLE.
- BUSY: hold all mem_* outputs stable. When mem_ready=1, capture mem_rdata into ch_rdata, clear mem_read/mem_write, set ch_ready[grant], then go to RESP.
- RESP: ch_ready[grant]=1 for exactly this cycle. Clear it at the next edge and go to IDLE. No grant is made in RESP.
- Requests not granted stay pending. The arbiter never drops them and the channel keeps holding them.
- If a channel deasserts after grant, the captured transaction still completes and ch_ready still pulses.
- mem_ready in IDLE or RESP is ignored.
- ch_rdata holds its last captured value until the next read completion. A write completion leaves ch_rdata unchanged.
- Arbitration policy is selected by the Configuration macro. The rr_ptr register holds the last granted index.

## Timing
- Reset, applied asynchronously at any time including mid-transaction, drives:
  - state=IDLE, mem_read=mem_write=0, mem_addr=0, mem_wdata=0
  - ch_ready=0, ch_rdata=0, grant=0, rr_ptr=N_CH-1
  - An in-flight memory access is abandoned.
- Request-to-memory latency: a request sampled in IDLE at edge k puts mem_read/mem_write high in cycle k+1.
- Completion: mem_ready sampled high at edge m drives, from cycle m+1:
  - mem_read=mem_write=0
  - ch_ready[grant]=1 and ch_rdata valid
- IDLE resumes at cycle m+2. The earliest next memory strobe is cycle m+3, so there are at least 2 strobe-low cycles between transactions.
- Best-case channel round trip is memory latency + 2 cycles.
- Memory sees a constant request for the whole of BUSY, so no glitch is exposed on mem_addr or mem_wdata.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - Search starts at (rr_ptr+1) mod N_CH and wraps at N_CH-1→0.
  - rr_ptr is updated to the winner at each grant.
  - No channel waits more than N_CH-1 grants.
- MEM_ARB_RR_EN undefined: fixed priority, lowest index wins.
  - rr_ptr is not implemented.
  - Channel 0 (I-cache by convention) can starve higher indices.

## Test plan
- Single read: ch_read=2'b01, ch_addr[0]=28'h000_0040, memory answers 128'hDEAD…BEEF after 5 cycles.
  - Required: mem_read=1 with mem_addr=28'h0000040 from cycle 1.
  - Required: ch_ready=2'b01 for exactly one cycle with ch_rdata=128'hDEAD…BEEF.
- Write-over-read and request withdrawal:
  - ch_read[1]=ch_write[1]=1 with wdata 128'h1234 → mem_write=1, mem_read=0, mem_wdata=128'h1234.
  - Channel deasserts mid-BUSY → ch_ready[1] still pulses after mem_ready.
- Contention with MEM_ARB_RR_EN: both channels request continuously for 4 transactions.
  - Required grant order is 0,1,0,1, with ≥2 strobe-low cycles between them.
- Contention without the macro: same stimulus.
  - Required grant order is 0,0,0,0; channel 1 is granted only after ch_read[0] drops.
- Reset mid-BUSY: assert proc_reset 2 cycles after grant.
  - Required: all outputs return to 0 immediately, with no ch_ready pulse.
  - Required: after release, the first grant goes to channel 0.
- Spurious mem_ready in IDLE: no state change and ch_ready stays 0. N_CH=4 RR: all four request → grants 0,1,2,3,0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter -- serialises N_CH cache-side line read/write requests onto one
// shared slow-memory port.
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   : round-robin arbitration, search starts after the last winner (rr_ptr)
//   undefined : fixed priority, lowest channel index wins (rr_ptr not built)
//
// Ports
//   clk, proc_reset        clock (rising edge), asynchronous active-high reset
//   ch_read/ch_write[i]    per-channel request, held until ch_ready[i]
//   ch_addr, ch_wdata      packed per-channel line address / write line
//   ch_rdata               registered read line, shared by all channels
//   ch_ready               one-hot, one-cycle completion pulse
//   mem_read/mem_write     registered memory strobes, stable for the whole access
//   mem_addr, mem_wdata    registered address / write line
//   mem_rdata, mem_ready   memory return data and one-cycle completion pulse
module mem_arbiter #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic                     clk,
    input  logic                     proc_reset,
    input  logic [N_CH-1:0]          ch_read,
    input  logic [N_CH-1:0]          ch_write,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*LINE_W-1:0]   ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [N_CH-1:0]          ch_ready,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic [LINE_W-1:0]        mem_rdata,
    input  logic                     mem_ready
);

    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0]   ch_rdata_q, ch_rdata_d;
    logic [N_CH-1:0]     ch_ready_q, ch_ready_d;

    logic [N_CH-1:0]     req;
    logic [GW-1:0]       win;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LINE_W-1:0]   sel_wdata;
    logic                sel_read;
    logic                sel_write;

    assign req = ch_read | ch_write;

`ifdef MEM_ARB_RR_EN
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW:0]   idx;

    // Walk the search order backwards so the last hit is the first channel
    // after rr_ptr; idx wraps at N_CH-1 -> 0.
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = {1'b0, rr_ptr_q} + (GW+1)'(i);
            if (idx >= (GW+1)'(N_CH)) idx = idx - (GW+1)'(N_CH);
            if (req[idx[GW-1:0]]) win = idx[GW-1:0];
        end
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        win = '0;
        for (int i = N_CH-1; i >= 0; i--) begin
            if (req[i]) win = GW'(i);
        end
    end
`endif

    // Mux the winner's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (win == GW'(i)) begin
                sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata[i*LINE_W +: LINE_W];
                sel_read  = ch_read[i];
                sel_write = ch_write[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ch_rdata_d  = ch_rdata_q;
        ch_ready_d  = '0;            // ready is a single-cycle pulse
`ifdef MEM_ARB_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d     = win;
                    // write beats read when a channel raises both
                    mem_write_d = sel_write;
                    mem_read_d  = sel_read & ~sel_write;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    state_d     = BUSY;
`ifdef MEM_ARB_RR_EN
                    rr_ptr_d    = win;
`endif
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    if (mem_read_q) ch_rdata_d = mem_rdata;
                    mem_read_d           = 1'b0;
                    mem_write_d          = 1'b0;
                    ch_ready_d[grant_q]  = 1'b1;
                    state_d              = RESP;
                end
            end
            RESP: begin
                // no grant here: guarantees two strobe-low cycles between accesses
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ch_rdata_q  <= '0;
            ch_ready_q  <= '0;
`ifdef MEM_ARB_RR_EN
            rr_ptr_q    <= GW'(N_CH-1);   // first search after reset starts at 0
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ch_rdata_q  <= ch_rdata_d;
            ch_ready_q  <= ch_ready_d;
`ifdef MEM_ARB_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ch_rdata  = ch_rdata_q;
    assign ch_ready  = ch_ready_q;

endmodule
